// File: rtl/kernel_merge3_rr.sv
// rtl/kernel_merge3_rr.sv - three-way round-robin burst merge of FIFO streams (optional MERGE3_TAG_EN source tag)
module kernel_merge3_rr #(
   parameter int WIDTH = 16,
   parameter int BURST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] input_S1,
   input  logic             avail_S1,
   output logic             read_S1,
   input  logic [WIDTH-1:0] input_S2,
   input  logic             avail_S2,
   output logic             read_S2,
   input  logic [WIDTH-1:0] input_S3,
   input  logic             avail_S3,
   output logic             read_S3,
   output logic [WIDTH-1:0] output_S4,
   output logic             write_S4,
   input  logic             full_S4,
`ifdef MERGE3_TAG_EN
   output logic [1:0]       output_tag_S4,
`endif
   output logic             running
);

   typedef enum logic [1:0] {
      ST_ARB  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   localparam logic [7:0] BURST_W = 8'(BURST);

   state_t           state, state_nx;
   logic [WIDTH-1:0] hold, hold_nx;
   logic [1:0]       cur, cur_nx;
   logic [7:0]       bcnt, bcnt_nx;
   logic             running_nx;
   logic [3:0]       av;
   logic [1:0]       win;
   logic             win_vld;
   logic             burst_go;
   logic [WIDTH-1:0] win_data;
   logic [2:0]       rd;

   // Bit 3 pads the vector so a 2-bit source index never reads out of range.
   assign av = {1'b0, avail_S3, avail_S2, avail_S1};

   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // Winner selection: keep the current source while its burst is open, otherwise rotate.
   always_comb begin
      win      = cur;
      win_vld  = 1'b0;
      burst_go = (bcnt != 8'd0) && (bcnt < BURST_W) && av[cur];
      if (burst_go) begin
         win     = cur;
         win_vld = 1'b1;
      end else if (av[next_src(cur)]) begin
         win     = next_src(cur);
         win_vld = 1'b1;
      end else if (av[next_src(next_src(cur))]) begin
         win     = next_src(next_src(cur));
         win_vld = 1'b1;
      end else if (av[cur]) begin
         win     = cur;
         win_vld = 1'b1;
      end
   end

   // Data mux for the selected source.
   always_comb begin
      case (win)
         2'd0:    win_data = input_S1;
         2'd1:    win_data = input_S2;
         default: win_data = input_S3;
      endcase
   end

   // Next-state and handshake outputs; reads and writes are masked while in reset.
   always_comb begin
      state_nx   = state;
      hold_nx    = hold;
      cur_nx     = cur;
      bcnt_nx    = bcnt;
      running_nx = 1'b1;
      rd         = 3'b000;
      write_S4   = 1'b0;
      case (state)
         ST_ARB: begin
            if (win_vld) begin
               rd       = 3'(3'b001 << win) & {3{rst}};
               hold_nx  = win_data;
               cur_nx   = win;
               state_nx = ST_EMIT;
               bcnt_nx  = burst_go ? bcnt + 8'd1 : 8'd1;
            end else begin
               running_nx = 1'b0;
               bcnt_nx    = 8'd0;
            end
         end
         ST_EMIT: begin
            write_S4 = rst && !full_S4;
            if (!full_S4) begin
               state_nx = ST_ARB;
               if (bcnt == BURST_W) bcnt_nx = 8'd0;
            end
         end
         default: state_nx = ST_ARB;
      endcase
   end

   assign read_S1   = rd[0];
   assign read_S2   = rd[1];
   assign read_S3   = rd[2];
   assign output_S4 = hold;

   // State register; reset hands first priority to S1 by parking cur on S3.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_ARB;
         hold    <= '0;
         cur     <= 2'd2;
         bcnt    <= 8'd0;
         running <= 1'b1;
      end else begin
         state   <= state_nx;
         hold    <= hold_nx;
         cur     <= cur_nx;
         bcnt    <= bcnt_nx;
         running <= running_nx;
      end
   end

`ifdef MERGE3_TAG_EN
   logic [1:0] tag_q;

   // Source index captured alongside hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q <= 2'd0;
      end else if (state == ST_ARB && win_vld) begin
         tag_q <= win;
      end
   end

   assign output_tag_S4 = tag_q;
`endif

endmodule

// File: tb/tb_kernel_merge3_rr.sv
// tb/tb_kernel_merge3_rr.sv - randomized scoreboard bench for kernel_merge3_rr at BURST 1 and 3
module tb_kernel_merge3_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din  [2][3];
   logic        av   [2][3];
   logic        rd   [2][3];
   logic [15:0] dout [2];
   logic        wr   [2];
   logic        full [2];
   logic        runo [2];
`ifdef MERGE3_TAG_EN
   logic [1:0]  tago [2];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      kernel_merge3_rr #(.WIDTH(16), .BURST(g == 0 ? 1 : 3)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .input_S1  (din[g][0]),
         .avail_S1  (av[g][0]),
         .read_S1   (rd[g][0]),
         .input_S2  (din[g][1]),
         .avail_S2  (av[g][1]),
         .read_S2   (rd[g][1]),
         .input_S3  (din[g][2]),
         .avail_S3  (av[g][2]),
         .read_S3   (rd[g][2]),
         .output_S4 (dout[g]),
         .write_S4  (wr[g]),
         .full_S4   (full[g]),
`ifdef MERGE3_TAG_EN
         .output_tag_S4 (tago[g]),
`endif
         .running   (runo[g])
      );
   end

   int          total = 0;
   int          bad   = 0;
   int          last    [2];
   int          runl    [2];
   bit          pend    [2];
   bit          exp_run [2];
   logic [15:0] expw    [2];
   int          expt    [2];
   bit          popped  [2][3];
   int          cnt     [2][3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int burst_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         last[d]    = 2;
         runl[d]    = 0;
         pend[d]    = 1'b0;
         exp_run[d] = 1'b1;
         for (int k = 0; k < 3; k++) popped[d][k] = 1'b0;
      end
   endtask

   // One cycle of the grant model: a word is either waiting for the consumer or a new grant is due.
   task automatic model_step(input int d);
      int w;
      bit cont;
      int ev;
      check($sformatf("running_d%0d", d), 32'(runo[d]), 32'(exp_run[d]));
      if (pend[d]) begin
         check($sformatf("noread_emit_d%0d", d), {29'd0, rd[d][2], rd[d][1], rd[d][0]}, 32'd0);
         check($sformatf("write_d%0d", d), 32'(wr[d]), 32'(!full[d]));
         check($sformatf("data_d%0d", d), 32'(dout[d]), 32'(expw[d]));
`ifdef MERGE3_TAG_EN
         check($sformatf("tag_d%0d", d), 32'(tago[d]), 32'(expt[d]));
`endif
         if (!full[d]) pend[d] = 1'b0;
         exp_run[d] = 1'b1;
      end else begin
         w    = -1;
         cont = (runl[d] > 0) && (runl[d] < burst_of(d)) && av[d][last[d]];
         if (cont) w = last[d];
         else begin
            for (int i = 1; i <= 3; i++) begin
               if (w < 0 && av[d][(last[d] + i) % 3]) w = (last[d] + i) % 3;
            end
         end
         ev = (w < 0) ? 0 : (1 << w);
         check($sformatf("grant_d%0d", d), {29'd0, rd[d][2], rd[d][1], rd[d][0]}, 32'(ev));
         check($sformatf("nowrite_arb_d%0d", d), 32'(wr[d]), 32'd0);
         if (w >= 0) begin
            expw[d]      = din[d][w];
            expt[d]      = w;
            pend[d]      = 1'b1;
            runl[d]      = cont ? runl[d] + 1 : 1;
            last[d]      = w;
            popped[d][w] = 1'b1;
            exp_run[d]   = 1'b1;
         end else begin
            runl[d]    = 0;
            exp_run[d] = 1'b0;
         end
      end
   endtask

   // Apply last cycle's pops to the producers and present the next inputs for this mode.
   task automatic drive(input int m);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 3; k++) begin
            if (popped[d][k]) cnt[d][k]++;
            popped[d][k] = 1'b0;
            din[d][k] = (m == 1) ? 16'(16'h1111 * (k + 1)) : {4'(k + 1), 12'(cnt[d][k])};
            case (m)
               0:       av[d][k] = 1'b0;
               3:       av[d][k] = ($urandom_range(0, 3) != 0);
               4:       av[d][k] = (k == 2);
               6:       av[d][k] = ($urandom_range(0, 2) == 0);
               default: av[d][k] = 1'b1;
            endcase
         end
         case (m)
            5:       full[d] = 1'b1;
            3, 6:    full[d] = ($urandom_range(0, 2) == 0);
            default: full[d] = 1'b0;
         endcase
      end
   endtask

   task automatic run_phase(input int m, input int n);
      for (int c = 0; c < n; c++) begin
         drive(m);
         @(negedge clk);
         model_step(0);
         model_step(1);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 3; k++) cnt[d][k] = k * 100;
      model_reset();
      rst = 1'b0;
      drive(2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_read_d%0d", d), {29'd0, rd[d][2], rd[d][1], rd[d][0]}, 32'd0);
         check($sformatf("rst_write_d%0d", d), 32'(wr[d]), 32'd0);
         check($sformatf("rst_data_d%0d", d), 32'(dout[d]), 32'd0);
         check($sformatf("rst_running_d%0d", d), 32'(runo[d]), 32'd1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();

      run_phase(0, 5);
      for (int d = 0; d < 2; d++)
         check($sformatf("idle_data_d%0d", d), 32'(dout[d]), 32'd0);
      run_phase(1, 30);
      run_phase(2, 40);
      run_phase(4, 30);
      run_phase(3, 500);
      run_phase(6, 300);

      run_phase(2, 3);
      run_phase(5, 6);
      drive(2);
      #1;
      for (int d = 0; d < 2; d++)
         check($sformatf("release_write_d%0d", d), 32'(wr[d]), 32'(pend[d]));
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("async_write_d%0d", d), 32'(wr[d]), 32'd0);
         check($sformatf("async_data_d%0d", d), 32'(dout[d]), 32'd0);
         check($sformatf("async_read_d%0d", d), {29'd0, rd[d][2], rd[d][1], rd[d][0]}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      run_phase(2, 20);
      run_phase(3, 300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kernel_merge3_rr.md
Name: kernel_merge3_rr

Overview:
- Round-robin arbiter that shares one downstream stream channel among three upstream producer FIFOs.
- Uses the same avail/read and full/write FIFO handshakes as the other generated kernels, so it drops in between producers and a single consumer (e.g. ahead of a Dup3-style fan-out).
- Words are granted in bursts of up to BURST per source, then the grant rotates.

Parameters:
- WIDTH, 16: data width of every stream.
- BURST, 1: maximum consecutive words granted to one source before rotation; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low; 0 = reset asserted.
- input_S1  input  WIDTH  producer 0 data.
- avail_S1  input  1  producer 0 has a word.
- read_S1  output  1  pop producer 0.
- input_S2  input  WIDTH  producer 1 data.
- avail_S2  input  1  producer 1 has a word.
- read_S2  output  1  pop producer 1.
- input_S3  input  WIDTH  producer 2 data.
- avail_S3  input  1  producer 2 has a word.
- read_S3  output  1  pop producer 2.
- output_S4  output  WIDTH  merged data, equal to the hold register.
- write_S4  output  1  push to consumer.
- full_S4  input  1  consumer cannot accept.
- running  output  1  kernel activity flag.

Behaviour:
- Registers:
  - hold (WIDTH).
  - state: 1 = ARB, 2 = EMIT.
  - cur: 2-bit, last granted source.
  - bcnt: 8-bit, words granted to cur in the current burst.
  - running.
- Reset (rst = 0, asynchronous): hold = 0, state = ARB, cur = 2 (first priority goes to S1), bcnt = 0, running = 1.
  - read_S1..S3 and write_S4 are forced to 0 while rst = 0.
  - output_S4 = 0.
- ARB (state 1):
  - Burst continues if bcnt != 0, bcnt < BURST and avail of cur = 1. Winner = cur.
  - Otherwise winner is the first source with avail = 1, scanning cur+1, cur+2, cur+3 (mod 3).
  - read_Sk of the winner is combinationally 1 in the same cycle, qualified by avail. All other reads are 0, so at most one read is high per cycle.
  - On a winner: hold <= input of winner; cur <= winner; state <= EMIT.
    - bcnt <= bcnt+1 if the burst continues.
    - bcnt <= 1 if the winner is a new source, or the same source starting a new burst.
    - If the new bcnt equals BURST, bcnt is cleared to 0 when EMIT completes, which forces rotation on the next ARB.
  - No avail at all: stay in ARB, running <= 0, bcnt <= 0 (a burst ends when its source runs dry).
- EMIT (state 2):
  - write_S4 = !full_S4, combinational.
  - On write: state <= ARB; if bcnt == BURST then bcnt <= 0.
  - full_S4 = 1: hold EMIT with hold stable for any number of cycles; no reads are issued.
- running <= 1 every cycle except the ARB-with-no-avail case.
- Timing:
  - Latency from read to write_S4 is 1 cycle minimum.
  - Peak throughput is 1 word per 2 cycles.
- Fairness: with all three sources continuously avail and BURST = 1, grant order is S1, S2, S3, S1, …
- Reset mid-EMIT:
  - The held word is discarded; no write is issued.
  - Upstream is unaffected because the read already completed.
- No data width conversion: data is passed unmodified.

Optional Feature:
- Macro MERGE3_TAG_EN.
- Defined:
  - Extra port output_tag_S4, output, 2 bits, equal to the source index (0..2) of hold.
  - Registered alongside hold; reset value 0; valid whenever write_S4 = 1.
- Undefined: the port is absent and the arbitration behaviour is identical.

Test Plan:
- Reset, then all avail = 0 for 5 cycles → no read or write; running = 0 from the 2nd cycle; output_S4 = 0.
- BURST = 1; all three sources avail with S1 = 0x1111, S2 = 0x2222, S3 = 0x3333, full_S4 = 0 → output sequence 1111, 2222, 3333, 1111…; one write every 2 cycles.
- BURST = 3; all sources avail → three words from S1, then three from S2, then three from S3.
  - S2's avail drops after 1 word → the burst ends and S3 is granted next.
- EMIT with full_S4 = 1 for 4 cycles → write_S4 = 0 and output_S4 stable; no read_S* pulses. On the full release cycle write_S4 = 1 once.
- Only S3 avail, BURST = 1 → S3 is granted every ARB cycle, with no stall waiting on idle sources.
- rst pulsed low asynchronously during EMIT (between clock edges) → write_S4 drops immediately and state returns to ARB. After release, the first grant goes to S1 when all sources are avail.
- MERGE3_TAG_EN build → output_tag_S4 is 0, 1, 2 in step with the data in the round-robin scenario.
